demux_route: RTL and testbench
==============================

Name: demux_route

Overview:
- 1-to-2 registered demultiplexer. It is the receive/steer counterpart of the 32-bit 2:1 select path.
- A single 32-bit producer stream is routed word by word to port a (sel=1) or port b (sel=0).
- Valid/ready handshakes are used on every side.
- Each output has its own 2-entry buffer, so one stalled consumer never corrupts or reorders the other's data.
- Sits between the datapath source and two independent consumers, e.g. two pipeline stages or units.

Parameters:
- W, 32, data word width in bits.
- DEPTH, 2, entries per output buffer; fixed at 2 in this revision; other values are not supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- y  input  W  input data word.
- sel  input  1  route select, sampled with y; 1 -> port a, 0 -> port b.
- y_valid  input  1  producer has a word on y/sel.
- y_ready  output  1  block accepts y this cycle.
- a  output  W  data at head of the a buffer.
- a_valid  output  1  a holds a valid word.
- a_ready  input  1  a consumer takes the word.
- b  output  W  data at head of the b buffer.
- b_valid  output  1  b holds a valid word.
- b_ready  input  1  b consumer takes the word.

Behaviour:
- Reset:
  - rst_n low clears both buffer counts, read pointers and write pointers immediately, without waiting for clk.
  - While reset is held and after release: y_ready=1, a_valid=0, b_valid=0, a=0, b=0.
  - Reset asserted mid-transfer discards all buffered words; nothing is replayed.
- Input transfer:
  - A word transfers on a rising edge where y_valid && y_ready.
  - y_ready = sel ? (cnt_a != 2) : (cnt_b != 2).
  - y_ready depends only on registered counts and sel, never on a_ready or b_ready.
  - y_ready may toggle with sel while y_valid is high.
  - The producer must hold y and sel stable until the transfer; this is a protocol requirement on the source.
- Output transfer:
  - Port a transfers on an edge where a_valid && a_ready; port b likewise.
  - a_valid = (cnt_a != 0); b_valid = (cnt_b != 0).
  - a and b always show the head entry of their buffer.
  - a and b show 0 when their buffer is empty; data outputs are gated, not stale.
- Latency:
  - A word accepted at edge N appears on its output with valid=1 immediately after edge N (1-cycle latency).
  - No combinational path from y to a or b.
- Per-buffer counts (0..2), per edge with push and pop:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. Legal at count 1; at count 2 push cannot occur because y_ready=0.
  - Pop with count 0: impossible, since valid=0.
  - Pointers are 1-bit and wrap 1->0.
- Ordering:
  - FIFO order is preserved within each port.
  - No ordering relationship between a and b.
- Independence:
  - A full b buffer with b_ready=0 must not block words with sel=1 from reaching a.
  - Both ports may pop in the same cycle that a push occurs to either port.
- y_valid=0: y and sel are ignored and no state changes, except pops.

Optional Feature:
- Macro DEMUX_ROUTE_CNT_EN.
- When defined:
  - Adds output ports a_cnt and b_cnt, 16 bits each.
  - Each counts completed output transfers on its port.
  - Increments by 1 per a or b handshake and wraps 0xFFFF -> 0x0000.
  - Cleared to 0 by rst_n.
- When undefined: the ports and counters are absent, with no other behavioural change.

Test Plan:
- Reset sequence: assert rst_n=0 mid-stream with 2 words buffered in a -> a_valid=0, b_valid=0, a=0, b=0, y_ready=1 with no clk edge required; after release the old words never reappear.
- Steer: send y=0x11111111 sel=1, then y=0x22222222 sel=0, with both readys high -> a=0x11111111 valid one cycle after its accept edge; b=0x22222222 valid one cycle after its accept edge; each is popped once.
- Backpressure: b_ready=0, send 3 words with sel=0 (0xB0,0xB1,0xB2) -> first two accepted; y_ready=0 while sel=0; then assert b_ready -> b delivers 0xB0, 0xB1, then 0xB2 is accepted and delivered, in order.
- Independence: b full, b_ready=0, then send 0xA5A5A5A5 sel=1 -> y_ready=1, accepted, and a=0xA5A5A5A5 a_valid=1 next cycle.
- Simultaneous push/pop at count 1 on a, streaming 0..9 with a_ready=1 -> one word per cycle, count stays 1, a outputs 0..9 in order, y_ready never drops.
- With DEMUX_ROUTE_CNT_EN: 65537 transfers on a -> a_cnt=1 (wrapped), b_cnt unchanged.

Source files
------------

// File: rtl/demux_route.sv
// 1-to-2 registered demultiplexer: each word on y is steered to port a (sel=1) or port b (sel=0).
// Each port has its own 2-entry FIFO. Define DEMUX_ROUTE_CNT_EN to add per-port transfer counters.
module demux_route #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] y,
    input  logic         sel,
    input  logic         y_valid,
    output logic         y_ready,
    output logic [W-1:0] a,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [W-1:0] b,
    output logic         b_valid,
    input  logic         b_ready
`ifdef DEMUX_ROUTE_CNT_EN
    ,
    output logic [15:0]  a_cnt,
    output logic [15:0]  b_cnt
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [1:0]   cnt_a_q, cnt_a_d;
    logic [1:0]   cnt_b_q, cnt_b_d;
    logic         wr_a_q, wr_a_d, rd_a_q, rd_a_d;
    logic         wr_b_q, wr_b_d, rd_b_q, rd_b_d;
    logic [W-1:0] mem_a_q [2];
    logic [W-1:0] mem_a_d [2];
    logic [W-1:0] mem_b_q [2];
    logic [W-1:0] mem_b_d [2];
    logic         push_a, push_b, pop_a, pop_b;

    function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic push,
                                            input logic pop);
        case ({push, pop})
            2'b10:   return cnt + 2'd1;
            2'b01:   return cnt - 2'd1;
            default: return cnt;
        endcase
    endfunction

    // Acceptance looks only at the registered count of the selected buffer, never at the consumers.
    assign y_ready = sel ? (cnt_a_q != FULL) : (cnt_b_q != FULL);
    assign a_valid = (cnt_a_q != 2'd0);
    assign b_valid = (cnt_b_q != 2'd0);

    assign push_a = y_valid && y_ready && sel;
    assign push_b = y_valid && y_ready && !sel;
    assign pop_a  = a_valid && a_ready;
    assign pop_b  = b_valid && b_ready;

    assign a = a_valid ? mem_a_q[rd_a_q] : '0;
    assign b = b_valid ? mem_b_q[rd_b_q] : '0;

    always_comb begin
        cnt_a_d = next_cnt(cnt_a_q, push_a, pop_a);
        cnt_b_d = next_cnt(cnt_b_q, push_b, pop_b);
        wr_a_d  = wr_a_q ^ push_a;
        rd_a_d  = rd_a_q ^ pop_a;
        wr_b_d  = wr_b_q ^ push_b;
        rd_b_d  = rd_b_q ^ pop_b;
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        if (push_a) mem_a_d[wr_a_q] = y;
        if (push_b) mem_b_d[wr_b_q] = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= 2'd0;
            cnt_b_q <= 2'd0;
            wr_a_q  <= 1'b0;
            rd_a_q  <= 1'b0;
            wr_b_q  <= 1'b0;
            rd_b_q  <= 1'b0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            wr_a_q  <= wr_a_d;
            rd_a_q  <= rd_a_d;
            wr_b_q  <= wr_b_d;
            rd_b_q  <= rd_b_d;
        end
    end

    // Storage needs no reset: outputs are gated by the counts.
    always_ff @(posedge clk) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
    end

`ifdef DEMUX_ROUTE_CNT_EN
    logic [15:0] a_cnt_q, a_cnt_d;
    logic [15:0] b_cnt_q, b_cnt_d;

    always_comb begin
        a_cnt_d = a_cnt_q + 16'(pop_a);
        b_cnt_d = b_cnt_q + 16'(pop_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= 16'd0;
            b_cnt_q <= 16'd0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_demux_route.sv
// Scoreboard bench for demux_route: expected words are queued per port on accept and
// compared when the corresponding output handshake occurs.
module tb_demux_route;

    logic        clk;
    logic        rst_n;
    logic [31:0] y;
    logic        sel;
    logic        y_valid;
    logic        y_ready;
    logic [31:0] a;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b;
    logic        b_valid;
    logic        b_ready;
`ifdef DEMUX_ROUTE_CNT_EN
    logic [15:0] a_cnt;
    logic [15:0] b_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int a_pops   = 0;
    int b_pops   = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    demux_route #(.W(32), .DEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .y       (y),
        .sel     (sel),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b       (b),
        .b_valid (b_valid),
        .b_ready (b_ready)
`ifdef DEMUX_ROUTE_CNT_EN
        ,
        .a_cnt   (a_cnt),
        .b_cnt   (b_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: every handshake pops the head of that port's expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && a_ready) begin
                check("a_pending", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) check("a_data", a, qa.pop_front());
                a_pops++;
            end
            if (b_valid && b_ready) begin
                check("b_pending", 32'(qb.size() != 0), 32'd1);
                if (qb.size() != 0) check("b_data", b, qb.pop_front());
                b_pops++;
            end
        end
    end

    // Drive one word, wait (bounded) for acceptance, and return 1 ns after the accept edge.
    task automatic send(input logic [31:0] data, input logic s);
        bit done;
        done    = 1'b0;
        y       = data;
        sel     = s;
        y_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (y_ready) begin
                if (s) qa.push_back(data);
                else   qb.push_back(data);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        y_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        y       = '0;
        sel     = 1'b0;
        y_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        #1;
        check("rst_y_ready", 32'(y_ready), 32'd1);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        check("rst_a", a, 32'd0);
        check("rst_b", b, 32'd0);
`ifdef DEMUX_ROUTE_CNT_EN
        check("rst_a_cnt", 32'(a_cnt), 32'd0);
        check("rst_b_cnt", 32'(b_cnt), 32'd0);
`endif
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Steer one word to each port with both consumers ready.
        a_ready = 1'b1;
        b_ready = 1'b1;
        send(32'h1111_1111, 1'b1);
        check("steer_a_valid", 32'(a_valid), 32'd1);
        check("steer_a", a, 32'h1111_1111);
        send(32'h2222_2222, 1'b0);
        check("steer_b_valid", 32'(b_valid), 32'd1);
        check("steer_b", b, 32'h2222_2222);
        idle(3);
        check("steer_a_once", 32'(a_valid), 32'd0);
        check("steer_b_once", 32'(b_valid), 32'd0);
        check("steer_qa_empty", 32'(qa.size()), 32'd0);
        check("steer_qb_empty", 32'(qb.size()), 32'd0);

        // Backpressure on b: third word must wait until the consumer drains.
        b_ready = 1'b0;
        send(32'h0000_00B0, 1'b0);
        send(32'h0000_00B1, 1'b0);
        y       = 32'h0000_00B2;
        sel     = 1'b0;
        y_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(y_ready), 32'd0);
            check("bp_head", b, 32'h0000_00B0);
        end
        @(posedge clk);
        #1;
        b_ready = 1'b1;
        send(32'h0000_00B2, 1'b0);
        idle(4);
        check("bp_drained", 32'(qb.size()), 32'd0);
        check("bp_b_empty", 32'(b_valid), 32'd0);

        // A full, stalled b must not block traffic to a.
        b_ready = 1'b0;
        a_ready = 1'b0;
        send(32'h0000_0BB0, 1'b0);
        send(32'h0000_0BB1, 1'b0);
        y       = 32'hA5A5_A5A5;
        sel     = 1'b1;
        #1;
        check("ind_ready", 32'(y_ready), 32'd1);
        send(32'hA5A5_A5A5, 1'b1);
        check("ind_a_valid", 32'(a_valid), 32'd1);
        check("ind_a", a, 32'hA5A5_A5A5);
        check("ind_b_head", b, 32'h0000_0BB0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        idle(4);
        check("ind_drained", 32'(qa.size() + qb.size()), 32'd0);

        // Streaming into a at count 1: push and pop on the same edge every cycle.
        for (int i = 0; i < 10; i++) begin
            y       = 32'(i);
            sel     = 1'b1;
            y_valid = 1'b1;
            @(negedge clk);
            check("stream_ready", 32'(y_ready), 32'd1);
            if (y_ready) qa.push_back(32'(i));
            @(posedge clk);
            #1;
            check("stream_a_valid", 32'(a_valid), 32'd1);
            check("stream_a", a, 32'(i));
        end
        y_valid = 1'b0;
        idle(3);
        check("stream_drained", 32'(qa.size()), 32'd0);

        // Asynchronous reset with two words buffered in a.
        a_ready = 1'b0;
        send(32'hC0DE_0001, 1'b1);
        send(32'hC0DE_0002, 1'b1);
        check("mid_full", 32'(y_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", 32'(a_valid), 32'd0);
        check("mid_rst_b_valid", 32'(b_valid), 32'd0);
        check("mid_rst_a", a, 32'd0);
        check("mid_rst_b", b, 32'd0);
        check("mid_rst_y_ready", 32'(y_ready), 32'd1);
`ifdef DEMUX_ROUTE_CNT_EN
        check("mid_rst_a_cnt", 32'(a_cnt), 32'd0);
`endif
        qa.delete();
        qb.delete();
        a_pops = 0;
        b_pops = 0;
        idle(1);
        rst_n   = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_a_valid", 32'(a_valid), 32'd0);
        end
        idle(1);

`ifdef DEMUX_ROUTE_CNT_EN
        begin
            logic [15:0] a_before;
            logic [15:0] b_before;
            a_before = a_cnt;
            b_before = b_cnt;
            y_valid  = 1'b1;
            sel      = 1'b1;
            for (int i = 0; i < 65537; i++) begin
                y = 32'(i) ^ 32'h5A00_0000;
                @(negedge clk);
                if (y_ready) qa.push_back(y);
                else check("cnt_stream_ready", 32'(y_ready), 32'd1);
                @(posedge clk);
                #1;
            end
            y_valid = 1'b0;
            idle(3);
            check("a_cnt_wrap", 32'(a_cnt), 32'(a_before + 16'd1));
            check("b_cnt_same", 32'(b_cnt), 32'(b_before));
            check("a_cnt_model", 32'(a_cnt), 32'(a_pops[15:0]));
        end
`endif

        check("final_qa_empty", 32'(qa.size()), 32'd0);
        check("final_qb_empty", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
